// File: rtl/brick_draw_pkg.sv
// brick_draw_pkg
//   Shared definitions for the brick rasteriser: default brick geometry,
//   the loader wait window derived from it, the health colour codes,
//   the FSM state type and small helper functions.
package brick_draw_pkg;

   localparam int unsigned BRICK_W_DEF = 16;
   localparam int unsigned BRICK_H_DEF = 8;

   // Loader wait window: every pixel plus the done cycle and the return to idle.
   localparam int unsigned BRICKDRAW = BRICK_W_DEF * BRICK_H_DEF + 2;

   localparam logic [2:0] COLOUR_HP0 = 3'b000;  // erase to background
   localparam logic [2:0] COLOUR_HP1 = 3'b010;
   localparam logic [2:0] COLOUR_HP2 = 3'b110;
   localparam logic [2:0] COLOUR_HP3 = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAW,
      S_DONE
   } state_t;

   function automatic logic [2:0] hp_colour(input logic [1:0] hp);
      logic [2:0] c;
      case (hp)
         2'd0:    c = COLOUR_HP0;
         2'd1:    c = COLOUR_HP1;
         2'd2:    c = COLOUR_HP2;
         default: c = COLOUR_HP3;
      endcase
      return c;
   endfunction

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/brick_draw_if.sv
// brick_draw_if
//   Bundle between the level loader / VGA adapter side and brick_draw.
//   Request side : draw_req, x_in, y_in, health_in (driven by master)
//   Pixel side   : x_out, y_out, colour, plot, busy, done (driven by slave)
interface brick_draw_if;

   logic       draw_req;
   logic [9:0] x_in;
   logic [9:0] y_in;
   logic [1:0] health_in;

   logic [9:0] x_out;
   logic [9:0] y_out;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic       done;

   modport master (
      output draw_req, x_in, y_in, health_in,
      input  x_out, y_out, colour, plot, busy, done
   );

   modport slave (
      input  draw_req, x_in, y_in, health_in,
      output x_out, y_out, colour, plot, busy, done
   );

endinterface

// File: rtl/brick_draw_pixel_counter.sv
// brick_pixel_counter
//   Raster counter walking px over 0..BRICK_W-1 and py over 0..BRICK_H-1.
//   clk    : system clock
//   resetn : synchronous active-low reset
//   clr    : force px = py = 0 (has priority over en)
//   en     : advance one pixel in raster order
//   px, py : current pixel offset inside the brick
//   last   : high while (px, py) is the final pixel of the brick
module brick_pixel_counter
   import brick_draw_pkg::*;
#(
   parameter int unsigned BRICK_W = BRICK_W_DEF,
   parameter int unsigned BRICK_H = BRICK_H_DEF,
   localparam int unsigned XW     = cnt_w(BRICK_W),
   localparam int unsigned YW     = cnt_w(BRICK_H)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          clr,
   input  logic          en,
   output logic [XW-1:0] px,
   output logic [YW-1:0] py,
   output logic          last
);

   logic [XW-1:0] px_q, px_d;
   logic [YW-1:0] py_q, py_d;
   logic          px_end;
   logic          py_end;

   assign px_end = (px_q == XW'(BRICK_W - 1));
   assign py_end = (py_q == YW'(BRICK_H - 1));

   always_comb begin
      px_d = px_q;
      py_d = py_q;
      if (clr) begin
         px_d = '0;
         py_d = '0;
      end else if (en) begin
         if (px_end) begin
            px_d = '0;
            // py wraps too, so the counter idles at (0,0) after the last pixel
            py_d = py_end ? '0 : py_q + YW'(1);
         end else begin
            px_d = px_q + XW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         px_q <= '0;
         py_q <= '0;
      end else begin
         px_q <= px_d;
         py_q <= py_d;
      end
   end

   assign px   = px_q;
   assign py   = py_q;
   assign last = px_end && py_end;

endmodule

// File: rtl/brick_draw.sv
// brick_draw
//   Rasterises one brick rectangle per draw request, one pixel per clock,
//   toward the VGA adapter. Origin and health are latched on accept; later
//   input changes and requests during a draw are ignored.
//   clk    : system clock
//   resetn : synchronous active-low reset
//   bus    : brick_draw_if.slave
//            draw_req/x_in/y_in/health_in  request from the loader
//            x_out/y_out/colour/plot       pixel stream to the VGA adapter
//            busy                          high while pixels are emitted
//            done                          one-cycle pulse after last pixel
module brick_draw
   import brick_draw_pkg::*;
#(
   parameter int unsigned BRICK_W = BRICK_W_DEF,
   parameter int unsigned BRICK_H = BRICK_H_DEF
) (
   input  logic         clk,
   input  logic         resetn,
   brick_draw_if.slave  bus
);

   localparam int unsigned XW = cnt_w(BRICK_W);
   localparam int unsigned YW = cnt_w(BRICK_H);

   state_t     state_q, state_d;
   logic [9:0] x_base_q, x_base_d;
   logic [9:0] y_base_q, y_base_d;
   logic [1:0] hp_q, hp_d;
   logic       plot_q, plot_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic          cnt_clr;
   logic          cnt_en;
   logic [XW-1:0] px;
   logic [YW-1:0] py;
   logic          last;

   brick_pixel_counter #(
      .BRICK_W (BRICK_W),
      .BRICK_H (BRICK_H)
   ) u_counter (
      .clk    (clk),
      .resetn (resetn),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .px     (px),
      .py     (py),
      .last   (last)
   );

   // plot/busy/done are registered from the next state so they line up
   // exactly with the state they describe.
   always_comb begin
      state_d  = state_q;
      x_base_d = x_base_q;
      y_base_d = y_base_q;
      hp_d     = hp_q;
      plot_d   = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.draw_req) begin
               x_base_d = bus.x_in;
               y_base_d = bus.y_in;
               hp_d     = bus.health_in;
               cnt_clr  = 1'b1;
               state_d  = S_DRAW;
               plot_d   = 1'b1;
               busy_d   = 1'b1;
            end
         end
         S_DRAW: begin
            cnt_en = 1'b1;
            if (last) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               plot_d = 1'b1;
               busy_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         x_base_q <= '0;
         y_base_q <= '0;
         hp_q     <= '0;
         plot_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_base_q <= x_base_d;
         y_base_q <= y_base_d;
         hp_q     <= hp_d;
         plot_q   <= plot_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // 10-bit sums wrap mod 1024; no clipping at the screen edge.
   assign bus.x_out  = x_base_q + 10'(px);
   assign bus.y_out  = y_base_q + 10'(py);
   assign bus.colour = hp_colour(hp_q);
   assign bus.plot   = plot_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

endmodule

// File: tb/tb_brick_draw.sv
// tb_brick_draw
//   Self-checking bench for brick_draw with default 16x8 bricks. Each
//   accepted request pushes its expected pixel stream into a scoreboard;
//   a monitor pops and compares on every plot cycle. Scenario tasks check
//   counts, timing and specific pixels inline.
module tb_brick_draw;

   localparam int W  = 16;
   localparam int H  = 8;
   localparam int WH = W * H;

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic [2:0] c;
   } pix_t;

   logic   clk;
   logic   resetn;
   int     checks;
   int     errors;
   pix_t   sb[$];

   brick_draw_if bus();

   brick_draw #(
      .BRICK_W (W),
      .BRICK_H (H)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] exp_colour(input logic [1:0] hp);
      logic [2:0] tbl [4];
      tbl[0] = 3'b000;
      tbl[1] = 3'b010;
      tbl[2] = 3'b110;
      tbl[3] = 3'b100;
      return tbl[hp];
   endfunction

   // Scoreboard monitor: every plot cycle must match the next expected pixel.
   always @(negedge clk) begin
      pix_t e;
      if (bus.plot === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL pixel_unexpected: got (%0d,%0d,%b) with nothing expected",
                     bus.x_out, bus.y_out, bus.colour);
         end else begin
            e = sb.pop_front();
            if (bus.x_out !== e.x || bus.y_out !== e.y || bus.colour !== e.c) begin
               errors++;
               $display("FAIL pixel: got (%0d,%0d,%b) expected (%0d,%0d,%b)",
                        bus.x_out, bus.y_out, bus.colour, e.x, e.y, e.c);
            end
         end
      end
      if (bus.busy !== bus.plot && resetn === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL busy_vs_plot: busy=%b plot=%b expected equal", bus.busy, bus.plot);
      end
   end

   task automatic push_brick(input logic [9:0] x, input logic [9:0] y, input logic [1:0] hp);
      pix_t e;
      for (int py = 0; py < H; py++) begin
         for (int px = 0; px < W; px++) begin
            e.x = 10'((int'(x) + px) % 1024);
            e.y = 10'((int'(y) + py) % 1024);
            e.c = exp_colour(hp);
            sb.push_back(e);
         end
      end
   endtask

   // Raise draw_req at a negedge; the following posedge is the accept edge T.
   task automatic start_draw(input logic [9:0] x, input logic [9:0] y, input logic [1:0] hp);
      @(negedge clk);
      bus.x_in      = x;
      bus.y_in      = y;
      bus.health_in = hp;
      bus.draw_req  = 1'b1;
      push_brick(x, y, hp);
   endtask

   task automatic test_reset;
      resetn        = 1'b0;
      bus.draw_req  = 1'b0;
      bus.x_in      = 10'd333;
      bus.y_in      = 10'd444;
      bus.health_in = 2'd3;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.x_out !== 10'd0 || bus.y_out !== 10'd0) begin
         errors++;
         $display("FAIL reset_xy: got (%0d,%0d) expected (0,0)", bus.x_out, bus.y_out);
      end
      checks++;
      if (bus.colour !== 3'b000) begin
         errors++;
         $display("FAIL reset_colour: got %b expected 000", bus.colour);
      end
      checks++;
      if ({bus.plot, bus.busy, bus.done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got plot/busy/done=%b expected 000",
                  {bus.plot, bus.busy, bus.done});
      end
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int plots, first_k, last_k, dones, done_k;
      logic [9:0] fx, fy, lx, ly;
      logic [2:0] lc;
      plots = 0; first_k = -1; last_k = -1; dones = 0; done_k = -1;
      fx = '0; fy = '0; lx = '0; ly = '0; lc = '0;
      start_draw(10'd40, 10'd20, 2'd3);
      for (int k = 1; k <= WH + 6; k++) begin
         @(negedge clk);
         if (k == 1) bus.draw_req = 1'b0;
         if (bus.plot === 1'b1) begin
            plots++;
            if (first_k < 0) begin first_k = k; fx = bus.x_out; fy = bus.y_out; end
            last_k = k; lx = bus.x_out; ly = bus.y_out; lc = bus.colour;
         end
         if (bus.done === 1'b1) begin dones++; done_k = k; end
      end
      checks++;
      if (plots !== WH) begin errors++; $display("FAIL basic_plots: got %0d expected %0d", plots, WH); end
      checks++;
      if (first_k !== 1 || last_k !== WH) begin
         errors++;
         $display("FAIL basic_window: got first %0d last %0d expected 1 %0d", first_k, last_k, WH);
      end
      checks++;
      if (fx !== 10'd40 || fy !== 10'd20) begin
         errors++;
         $display("FAIL basic_first_pixel: got (%0d,%0d) expected (40,20)", fx, fy);
      end
      checks++;
      if (lx !== 10'd55 || ly !== 10'd27 || lc !== 3'b100) begin
         errors++;
         $display("FAIL basic_last_pixel: got (%0d,%0d,%b) expected (55,27,100)", lx, ly, lc);
      end
      checks++;
      if (dones !== 1 || done_k !== WH + 1) begin
         errors++;
         $display("FAIL basic_done: got %0d pulses at %0d expected 1 at %0d", dones, done_k, WH + 1);
      end
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL basic_sb_left: got %0d expected 0", sb.size()); end
      sb.delete();
   endtask

   task automatic test_hp0;
      int plots, done_k;
      plots = 0; done_k = -1;
      start_draw(10'd0, 10'd0, 2'd0);
      for (int k = 1; k <= WH + 6; k++) begin
         @(negedge clk);
         if (k == 1) bus.draw_req = 1'b0;
         if (bus.plot === 1'b1) plots++;
         if (bus.done === 1'b1) done_k = k;
      end
      checks++;
      if (plots !== WH || done_k !== WH + 1) begin
         errors++;
         $display("FAIL hp0_count: got %0d plots done at %0d expected %0d at %0d", plots, done_k, WH, WH + 1);
      end
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL hp0_sb_left: got %0d expected 0", sb.size()); end
      sb.delete();
   endtask

   task automatic test_wrap;
      int plots;
      logic [9:0] x5, y5, lx, ly;
      logic [2:0] lc;
      plots = 0; x5 = '1; y5 = '1; lx = '1; ly = '1; lc = '1;
      start_draw(10'd1020, 10'd1020, 2'd1);
      for (int k = 1; k <= WH + 6; k++) begin
         @(negedge clk);
         if (k == 1) bus.draw_req = 1'b0;
         if (bus.plot === 1'b1) plots++;
         if (k == 5) begin x5 = bus.x_out; y5 = bus.y_out; end
         if (k == WH) begin lx = bus.x_out; ly = bus.y_out; lc = bus.colour; end
      end
      checks++;
      if (x5 !== 10'd0 || y5 !== 10'd1020) begin
         errors++;
         $display("FAIL wrap_px4: got (%0d,%0d) expected (0,1020)", x5, y5);
      end
      checks++;
      if (lx !== 10'd11 || ly !== 10'd3 || lc !== 3'b010) begin
         errors++;
         $display("FAIL wrap_last: got (%0d,%0d,%b) expected (11,3,010)", lx, ly, lc);
      end
      checks++;
      if (plots !== WH || sb.size() !== 0) begin
         errors++;
         $display("FAIL wrap_count: got %0d plots %0d left expected %0d 0", plots, sb.size(), WH);
      end
      sb.delete();
   endtask

   task automatic test_ignore_mid_draw;
      int plots, dones, done_k;
      plots = 0; dones = 0; done_k = -1;
      start_draw(10'd100, 10'd200, 2'd1);
      for (int k = 1; k <= WH + 6; k++) begin
         @(negedge clk);
         if (k == 1) bus.draw_req = 1'b0;
         if (k == 10) bus.x_in = 10'd777;
         if (k == 50) begin
            bus.draw_req  = 1'b1;
            bus.x_in      = 10'd300;
            bus.y_in      = 10'd300;
            bus.health_in = 2'd0;
         end
         if (k == 51) bus.draw_req = 1'b0;
         if (bus.plot === 1'b1) plots++;
         if (bus.done === 1'b1) begin dones++; done_k = k; end
      end
      checks++;
      if (plots !== WH || dones !== 1 || done_k !== WH + 1) begin
         errors++;
         $display("FAIL ignore_count: got %0d plots %0d done at %0d expected %0d 1 at %0d",
                  plots, dones, done_k, WH, WH + 1);
      end
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL ignore_sb_left: got %0d expected 0", sb.size()); end
      sb.delete();
   endtask

   task automatic test_reset_mid_draw;
      int plots, done_k;
      plots = 0;
      start_draw(10'd500, 10'd400, 2'd2);
      for (int k = 1; k <= 61; k++) begin
         @(negedge clk);
         if (k == 1) bus.draw_req = 1'b0;
         if (k <= 60 && bus.plot === 1'b1) plots++;
         if (k == 60) resetn = 1'b0;
         if (k == 61) begin
            checks++;
            if ({bus.plot, bus.busy, bus.done} !== 3'b000 || bus.x_out !== 10'd0 ||
                bus.y_out !== 10'd0 || bus.colour !== 3'b000) begin
               errors++;
               $display("FAIL midreset_outputs: got plot/busy/done=%b xy=(%0d,%0d) c=%b expected 000 (0,0) 000",
                        {bus.plot, bus.busy, bus.done}, bus.x_out, bus.y_out, bus.colour);
            end
            resetn = 1'b1;
         end
      end
      checks++;
      if (plots !== 60) begin errors++; $display("FAIL midreset_partial: got %0d plots expected 60", plots); end
      sb.delete();
      plots = 0; done_k = -1;
      start_draw(10'd8, 10'd16, 2'd2);
      for (int k = 1; k <= WH + 6; k++) begin
         @(negedge clk);
         if (k == 1) bus.draw_req = 1'b0;
         if (bus.plot === 1'b1) plots++;
         if (bus.done === 1'b1) done_k = k;
      end
      checks++;
      if (plots !== WH || done_k !== WH + 1 || sb.size() !== 0) begin
         errors++;
         $display("FAIL midreset_redraw: got %0d plots done at %0d %0d left expected %0d at %0d 0",
                  plots, done_k, sb.size(), WH, WH + 1);
      end
      sb.delete();
   endtask

   task automatic test_back_to_back;
      int plots, dones, done1, done2, second_first;
      plots = 0; dones = 0; done1 = -1; done2 = -1; second_first = -1;
      start_draw(10'd600, 10'd300, 2'd2);
      push_brick(10'd600, 10'd300, 2'd2);
      for (int k = 1; k <= 2 * (WH + 2) + 6; k++) begin
         @(negedge clk);
         if (k == 200) bus.draw_req = 1'b0;
         if (bus.plot === 1'b1) begin
            plots++;
            if (k > WH + 1 && second_first < 0) second_first = k;
         end
         if (bus.done === 1'b1) begin
            dones++;
            if (dones == 1) done1 = k; else done2 = k;
         end
      end
      checks++;
      if (plots !== 2 * WH || dones !== 2) begin
         errors++;
         $display("FAIL b2b_count: got %0d plots %0d dones expected %0d 2", plots, dones, 2 * WH);
      end
      checks++;
      if (done1 !== WH + 1 || done2 !== 2 * WH + 3 || second_first !== WH + 3) begin
         errors++;
         $display("FAIL b2b_timing: got done %0d,%0d second start %0d expected %0d,%0d %0d",
                  done1, done2, second_first, WH + 1, 2 * WH + 3, WH + 3);
      end
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL b2b_sb_left: got %0d expected 0", sb.size()); end
      sb.delete();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_hp0();
      test_wrap();
      test_ignore_mid_draw();
      test_reset_mid_draw();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
